// File: rtl/cu_cfg_pkg.sv
// Shared types and constants for the compute-unit configuration loader.
package cu_cfg_pkg;

  localparam logic [7:0]  CFG_HEADER    = 8'hA5;
  localparam int unsigned CFG_FRAME_LEN = 7;
  localparam int unsigned CU_FIELD_W    = 7;
  localparam int unsigned CNT_W         = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_ARMED  = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  // Field order mirrors the byte order of B1..B5 on the wire
  typedef struct packed {
    logic                  rmux0;
    logic [CU_FIELD_W-1:0] opcode;
    logic                  opa_is_local;
    logic [CU_FIELD_W-1:0] opa_local;
    logic                  rmux1;
    logic [CU_FIELD_W-1:0] opa_remote;
    logic                  opb_is_local;
    logic [CU_FIELD_W-1:0] opb_local;
    logic [CU_FIELD_W-1:0] opb_remote;
  } cu_cfg_t;

endpackage

// File: rtl/cu_cfg_frame_assembler.sv
// Positional capture of frame bytes B1..B6 into shadow registers with a running XOR.
module cu_cfg_frame_assembler
  import cu_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hdr_i,
  input  logic       data_i,
  input  logic       clear_i,
  input  logic [7:0] byte_i,
  output logic       last_o,
  output logic       csum_ok_o,
  output cu_cfg_t    shadow_o
);

  logic [CNT_W-1:0] count_q;
  logic [7:0]       xor_q;
  logic [7:0]       csum_q;
  cu_cfg_t          shadow_q;

  assign last_o    = data_i && (count_q == CNT_W'(CFG_FRAME_LEN - 1));
  assign csum_ok_o = (xor_q == csum_q);
  assign shadow_o  = shadow_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q  <= '0;
      xor_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
    end else if (hdr_i) begin
      count_q <= CNT_W'(1);
      xor_q   <= '0;
    end else if (data_i) begin
      count_q <= count_q + CNT_W'(1);
      if (!last_o) begin
        xor_q <= xor_q ^ byte_i;
      end
      case (count_q)
        3'd1:    {shadow_q.rmux0, shadow_q.opcode}           <= byte_i;
        3'd2:    {shadow_q.opa_is_local, shadow_q.opa_local} <= byte_i;
        3'd3:    {shadow_q.rmux1, shadow_q.opa_remote}       <= byte_i;
        3'd4:    {shadow_q.opb_is_local, shadow_q.opb_local} <= byte_i;
        3'd5:    shadow_q.opb_remote                         <= byte_i[CU_FIELD_W-1:0];
        3'd6:    csum_q                                      <= byte_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cu_config_loader.sv
// Loads a checksummed config frame, commits it atomically and runs the compute-unit launch handshake.
module cu_config_loader
  import cu_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_cfg_valid,
  input  logic [7:0]            io_cfg_data,
  output logic                  io_cfg_ready,
  input  logic                  io_start,
  input  logic                  io_cu_done,
  output logic                  io_config_enable,
  output logic                  io_enable,
  output logic [CU_FIELD_W-1:0] io_opcode,
  output logic                  io_rmux0,
  output logic                  io_rmux1,
  output logic                  io_opA_isLocal,
  output logic [CU_FIELD_W-1:0] io_opA_local,
  output logic [CU_FIELD_W-1:0] io_opA_remote,
  output logic                  io_opB_isLocal,
  output logic [CU_FIELD_W-1:0] io_opB_local,
  output logic [CU_FIELD_W-1:0] io_opB_remote,
  output logic                  io_busy,
  output logic                  io_error
);

  state_e  state_q, state_d;
  cu_cfg_t cfg_q, shadow;
  logic    cfg_loaded_q, error_q, cfg_en_q;
  logic    ready_c, accept_c, hdr_c, stray_c, data_c, start_c, last_c, csum_ok_c, clear_c;

  cu_cfg_frame_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .hdr_i     (hdr_c),
    .data_i    (data_c),
    .clear_i   (clear_c),
    .byte_i    (io_cfg_data),
    .last_o    (last_c),
    .csum_ok_o (csum_ok_c),
    .shadow_o  (shadow)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hdr_c) state_d = ST_LOAD;
      ST_LOAD:   if (last_c) state_d = ST_COMMIT;
      ST_COMMIT: state_d = (csum_ok_c || cfg_loaded_q) ? ST_ARMED : ST_IDLE;
      ST_ARMED:  begin
        if (start_c)    state_d = ST_RUN;
        else if (hdr_c) state_d = ST_LOAD;
      end
      ST_RUN:    if (io_cu_done) state_d = ST_ARMED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Start has priority over an incoming byte while armed
  always_comb begin
    ready_c  = 1'b0;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: ready_c = 1'b1;
      ST_ARMED: begin
        ready_c = !io_start;
        start_c = io_start;
      end
      default: ;
    endcase
    accept_c = io_cfg_valid && ready_c;
    hdr_c    = accept_c && (state_q != ST_LOAD) && (io_cfg_data == CFG_HEADER);
    stray_c  = accept_c && (state_q != ST_LOAD) && (io_cfg_data != CFG_HEADER);
    data_c   = accept_c && (state_q == ST_LOAD);
    clear_c  = (state_q == ST_COMMIT) && !csum_ok_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q        <= '0;
      cfg_loaded_q <= 1'b0;
      error_q      <= 1'b0;
      cfg_en_q     <= 1'b0;
    end else begin
      cfg_en_q <= 1'b0;
      if (state_q == ST_COMMIT) begin
        if (csum_ok_c) begin
          cfg_q        <= shadow;
          cfg_loaded_q <= 1'b1;
          error_q      <= 1'b0;
          cfg_en_q     <= 1'b1;
        end else begin
          error_q <= 1'b1;
        end
      end else if (stray_c) begin
        error_q <= 1'b1;
      end
    end
  end

  assign io_cfg_ready     = ready_c;
  assign io_config_enable = cfg_en_q;
  assign io_enable        = (state_q == ST_RUN);
  assign io_busy          = (state_q == ST_RUN);
  assign io_error         = error_q;
  assign io_opcode        = cfg_q.opcode;
  assign io_rmux0         = cfg_q.rmux0;
  assign io_rmux1         = cfg_q.rmux1;
  assign io_opA_isLocal   = cfg_q.opa_is_local;
  assign io_opA_local     = cfg_q.opa_local;
  assign io_opA_remote    = cfg_q.opa_remote;
  assign io_opB_isLocal   = cfg_q.opb_is_local;
  assign io_opB_local     = cfg_q.opb_local;
  assign io_opB_remote    = cfg_q.opb_remote;

endmodule

// File: tb/tb_cu_config_loader.sv
// Directed bench for cu_config_loader: per-cycle vector table plus hand-written corner sequences.
module tb_cu_config_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_cfg_valid;
  logic [7:0] io_cfg_data;
  logic       io_cfg_ready;
  logic       io_start, io_cu_done;
  logic       io_config_enable, io_enable;
  logic [6:0] io_opcode, io_opA_local, io_opA_remote, io_opB_local, io_opB_remote;
  logic       io_rmux0, io_rmux1, io_opA_isLocal, io_opB_isLocal;
  logic       io_busy, io_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cu_config_loader dut (
    .clk              (clk),
    .reset            (reset),
    .io_cfg_valid     (io_cfg_valid),
    .io_cfg_data      (io_cfg_data),
    .io_cfg_ready     (io_cfg_ready),
    .io_start         (io_start),
    .io_cu_done       (io_cu_done),
    .io_config_enable (io_config_enable),
    .io_enable        (io_enable),
    .io_opcode        (io_opcode),
    .io_rmux0         (io_rmux0),
    .io_rmux1         (io_rmux1),
    .io_opA_isLocal   (io_opA_isLocal),
    .io_opA_local     (io_opA_local),
    .io_opA_remote    (io_opA_remote),
    .io_opB_isLocal   (io_opB_isLocal),
    .io_opB_local     (io_opB_local),
    .io_opB_remote    (io_opB_remote),
    .io_busy          (io_busy),
    .io_error         (io_error)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       start;
    logic       done;
    logic       ready;
    logic       cfgen;
    logic       en;
    logic       busy;
    logic       err;
    logic [6:0] op;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  localparam logic [55:0] GOOD  = 56'hA5_83_85_02_09_11_1C;
  localparam logic [55:0] INNER = 56'hA5_A5_80_00_00_00_25;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic s, input logic dn,
                              input logic r, input logic ce, input logic e, input logic b,
                              input logic er, input logic [6:0] op);
    vec_t t;
    t.valid = v; t.data = d; t.start = s; t.done = dn;
    t.ready = r; t.cfgen = ce; t.en = e; t.busy = b; t.err = er; t.op = op;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    io_cfg_valid = 1'b0; io_cfg_data = 8'h00; io_start = 1'b0; io_cu_done = 1'b0;
  endtask

  function automatic logic [38:0] cfg_of(input logic [55:0] f);
    return {f[47:16], f[14:8]};
  endfunction

  task automatic chk_cfg(input string nm, input logic [38:0] exp);
    chk(nm, 64'({io_rmux0, io_opcode, io_opA_isLocal, io_opA_local, io_rmux1, io_opA_remote,
                 io_opB_isLocal, io_opB_local, io_opB_remote}), 64'(exp));
  endtask

  task automatic chk_flags(input string nm, input logic ce, input logic en, input logic busy, input logic err);
    chk({nm, "_cfgen"}, 64'(io_config_enable), 64'(ce));
    chk({nm, "_en"},    64'(io_enable),        64'(en));
    chk({nm, "_busy"},  64'(io_busy),          64'(busy));
    chk({nm, "_err"},   64'(io_error),         64'(err));
  endtask

  // Sends all 7 bytes; returns one cycle after B6 was accepted (state COMMIT)
  task automatic send_frame(input logic [55:0] f);
    for (int i = 0; i < 7; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = f[55-8*i -: 8];
      cyc();
    end
    idle_in();
  endtask

  task automatic do_reset(input string nm);
    idle_in();
    reset = 1'b1;
    cyc();
    cyc();
    chk_cfg({nm, "_cfg"}, 39'd0);
    chk_flags(nm, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //         v  data   st dn  rdy ce en bz er op
    tbl[0]  = mk(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[1]  = mk(1, 8'h83, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[2]  = mk(1, 8'h85, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[3]  = mk(1, 8'h02, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[4]  = mk(1, 8'h09, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[5]  = mk(1, 8'h11, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[6]  = mk(1, 8'h1C, 0, 0, 1, 0, 0, 0, 0, 7'd0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 7'd0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 7'd3);
    tbl[9]  = mk(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 7'd3);
    tbl[10] = mk(1, 8'h3C, 0, 0, 0, 0, 1, 1, 0, 7'd3);
    tbl[11] = mk(0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 7'd3);
    tbl[12] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 7'd3);
    tbl[13] = mk(0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 7'd3);
    tbl[14] = mk(1, 8'h3C, 0, 0, 1, 0, 0, 0, 0, 7'd3);
    tbl[15] = mk(1, 8'hA5, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[16] = mk(1, 8'h84, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[17] = mk(1, 8'h85, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[18] = mk(1, 8'h02, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[19] = mk(1, 8'h09, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[20] = mk(1, 8'h11, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[21] = mk(1, 8'h1C, 0, 0, 1, 0, 0, 0, 1, 7'd3);
    tbl[22] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 7'd3);
    tbl[23] = mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 7'd3);
    tbl[24] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 7'd3);

    do_reset("rst0");

    // Inputs driven just after an edge, outputs checked mid-cycle before the consuming edge
    for (int i = 0; i < NV; i++) begin
      io_cfg_valid = tbl[i].valid;
      io_cfg_data  = tbl[i].data;
      io_start     = tbl[i].start;
      io_cu_done   = tbl[i].done;
      #4;
      chk($sformatf("v%0d_ready", i), 64'(io_cfg_ready), 64'(tbl[i].ready));
      chk($sformatf("v%0d_cfgen", i), 64'(io_config_enable), 64'(tbl[i].cfgen));
      chk($sformatf("v%0d_en", i),    64'(io_enable), 64'(tbl[i].en));
      chk($sformatf("v%0d_busy", i),  64'(io_busy), 64'(tbl[i].busy));
      chk($sformatf("v%0d_err", i),   64'(io_error), 64'(tbl[i].err));
      chk($sformatf("v%0d_op", i),    64'(io_opcode), 64'(tbl[i].op));
      cyc();
    end
    idle_in();
    #1;
    chk_cfg("badcrc_keep_cfg", cfg_of(GOOD));

    // Reset while armed, then stray byte and ignored start in IDLE
    do_reset("rst1");
    io_start = 1'b1;
    cyc();
    io_start = 1'b0;
    #1;
    chk("idle_start_busy", 64'(io_busy), 64'(1'b0));
    io_cfg_valid = 1'b1; io_cfg_data = 8'h3C;
    cyc();
    idle_in();
    #1;
    chk("stray_err", 64'(io_error), 64'(1'b1));
    chk("stray_ready_idle", 64'(io_cfg_ready), 64'(1'b1));
    io_start = 1'b1;
    #1;
    chk("idle_ready_with_start", 64'(io_cfg_ready), 64'(1'b1));
    cyc();
    io_start = 1'b0;
    #1;
    chk("idle_start_ignored", 64'(io_busy), 64'(1'b0));

    send_frame(GOOD);
    #1;
    chk("commit_ready", 64'(io_cfg_ready), 64'(1'b0));
    chk("commit_err_still", 64'(io_error), 64'(1'b1));
    cyc();
    chk_cfg("good_cfg", cfg_of(GOOD));
    chk_flags("good_post", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("cfgen_one_cycle", 64'(io_config_enable), 64'(1'b0));

    // Reset after B3 of a frame, then a fresh frame commits
    for (int i = 0; i < 4; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = GOOD[55-8*i -: 8];
      cyc();
    end
    do_reset("rst_mid");
    send_frame(GOOD);
    cyc();
    chk_cfg("after_midrst_cfg", cfg_of(GOOD));
    chk_flags("after_midrst", 1'b1, 1'b0, 1'b0, 1'b0);

    // Header value inside the frame body is plain data
    send_frame(INNER);
    cyc();
    chk_cfg("inner_a5_cfg", cfg_of(INNER));
    chk_flags("inner_a5", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
